// File: rtl/imem_row_scheduler.sv
// Input-row memory scheduler: pushes each PE its first row per timestep, then serves
// row requests round-robin and broadcasts OP_TIMESTEP_DONE once every PE is full.
module imem_row_scheduler #(
    parameter int NUM_PE        = 5,
    parameter int ROWS_PER_PE   = 5,
    parameter int NUM_TIMESTEPS = 10,
    parameter int DATA_W        = 25,
    parameter int ADDR_W        = 9,
    parameter int IMEM_ID       = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NUM_PE-1:0] req,
    output logic [NUM_PE-1:0] req_ack,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32:0]       out_packet,
    output logic              busy,
    output logic              ts_done,
    output logic [3:0]        ts_count,
    output logic              err
);

    localparam int         PE_W       = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int         CNT_W      = $clog2(ROWS_PER_PE + 1);
    localparam logic [3:0] OP_INPUT   = 4'd1;
    localparam logic [3:0] OP_TS_DONE = 4'd15;

    // Packet fields are 4-bit node IDs around a 25-bit payload.
    if (NUM_PE > 16 || DATA_W != 25 || IMEM_ID < 0 || IMEM_ID > 15) begin : g_cfg_check
        $error("imem_row_scheduler: unsupported parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_READ, S_SEND, S_BCAST} state_t;

    state_t            state_q, state_d;
    logic [NUM_PE-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]  row_cnt_q [NUM_PE];
    logic [CNT_W-1:0]  row_cnt_d [NUM_PE];
    logic [PE_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PE_W-1:0]   gnt_q, gnt_d;
    logic [PE_W-1:0]   bcast_idx_q, bcast_idx_d;
    logic [DATA_W-1:0] row_q, row_d;
    logic [3:0]        ts_count_q, ts_count_d;
    logic              err_q, err_d;
    logic              ts_done_q, ts_done_d;
    logic [NUM_PE-1:0] req_ack_q, req_ack_d;

    logic              found;
    logic [PE_W-1:0]   sel;
    logic              all_full;
    logic              inflight;
    logic              last_bcast;
    logic              last_ts;

    // Round-robin search starting at rr_ptr_q.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (!found && pend_q[(int'(rr_ptr_q) + i) % NUM_PE]) begin
                found = 1'b1;
                sel   = PE_W'((int'(rr_ptr_q) + i) % NUM_PE);
            end
        end
    end

    always_comb begin
        all_full = 1'b1;
        for (int p = 0; p < NUM_PE; p++) begin
            if (row_cnt_q[p] != CNT_W'(ROWS_PER_PE)) all_full = 1'b0;
        end
    end

    assign inflight   = (state_q == S_READ) || (state_q == S_SEND);
    assign last_bcast = (bcast_idx_q == PE_W'(NUM_PE - 1));
    assign last_ts    = ((ts_count_q + 4'd1) == 4'(NUM_TIMESTEPS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ARB;
            S_ARB: begin
                if (found)         state_d = S_READ;
                else if (all_full) state_d = S_BCAST;
            end
            S_READ:  state_d = S_SEND;
            S_SEND:  if (out_ready) state_d = S_ARB;
            S_BCAST: if (out_ready && last_bcast) state_d = last_ts ? S_IDLE : S_ARB;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        out_valid   = 1'b0;
        out_packet  = '0;
        busy        = (state_q != S_IDLE);
        case (state_q)
            S_ARB: begin
                if (found) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = ADDR_W'(32'(ts_count_q) * 32'(NUM_PE * ROWS_PER_PE)
                                        + 32'(sel) * 32'(ROWS_PER_PE)
                                        + 32'(row_cnt_q[sel]));
                end
            end
            S_SEND: begin
                out_valid  = 1'b1;
                out_packet = {4'(gnt_q), OP_INPUT, row_q};
            end
            S_BCAST: begin
                out_valid  = 1'b1;
                out_packet = {4'(bcast_idx_q), OP_TS_DONE, {DATA_W{1'b0}}};
            end
            default: ;
        endcase
    end

    always_comb begin
        pend_d      = pend_q;
        row_cnt_d   = row_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        bcast_idx_d = bcast_idx_q;
        row_d       = row_q;
        ts_count_d  = ts_count_q;
        err_d       = err_q;
        ts_done_d   = 1'b0;
        req_ack_d   = '0;
        if (state_q == S_IDLE) begin
            if (start) begin
                ts_count_d = '0;
                pend_d     = '1;
                rr_ptr_d   = '0;
                for (int p = 0; p < NUM_PE; p++) row_cnt_d[p] = '0;
            end
        end else begin
            // A row already granted but not yet delivered counts toward the PE's quota.
            for (int p = 0; p < NUM_PE; p++) begin
                if (req[p] && !pend_q[p]) begin
                    req_ack_d[p] = 1'b1;
                    if (row_cnt_q[p] == CNT_W'(ROWS_PER_PE) ||
                        (inflight && gnt_q == PE_W'(p) &&
                         row_cnt_q[p] == CNT_W'(ROWS_PER_PE - 1)))
                        err_d = 1'b1;
                    else
                        pend_d[p] = 1'b1;
                end
            end
            case (state_q)
                S_ARB: begin
                    if (found) begin
                        pend_d[sel] = 1'b0;
                        gnt_d       = sel;
                        rr_ptr_d    = (sel == PE_W'(NUM_PE - 1)) ? '0 : sel + PE_W'(1);
                    end else if (all_full) begin
                        bcast_idx_d = '0;
                    end
                end
                S_READ: row_d = mem_rd_data;
                S_SEND: begin
                    if (out_ready) row_cnt_d[gnt_q] = row_cnt_q[gnt_q] + CNT_W'(1);
                end
                S_BCAST: begin
                    if (out_ready) begin
                        if (last_bcast) begin
                            ts_done_d  = 1'b1;
                            ts_count_d = ts_count_q + 4'd1;
                            if (!last_ts) begin
                                pend_d   = '1;
                                rr_ptr_d = '0;
                                for (int p = 0; p < NUM_PE; p++) row_cnt_d[p] = '0;
                            end
                        end else begin
                            bcast_idx_d = bcast_idx_q + PE_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            bcast_idx_q <= '0;
            row_q       <= '0;
            ts_count_q  <= '0;
            err_q       <= 1'b0;
            ts_done_q   <= 1'b0;
            req_ack_q   <= '0;
            for (int p = 0; p < NUM_PE; p++) row_cnt_q[p] <= '0;
        end else begin
            pend_q      <= pend_d;
            row_cnt_q   <= row_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            bcast_idx_q <= bcast_idx_d;
            row_q       <= row_d;
            ts_count_q  <= ts_count_d;
            err_q       <= err_d;
            ts_done_q   <= ts_done_d;
            req_ack_q   <= req_ack_d;
        end
    end

    assign req_ack  = req_ack_q;
    assign ts_done  = ts_done_q;
    assign ts_count = ts_count_q;
    assign err      = err_q;

endmodule

// File: tb/tb_imem_row_scheduler.sv
// Directed bench for imem_row_scheduler: two-timestep run, round-robin fairness,
// backpressure, over-request error and asynchronous reset mid-send.
module tb_imem_row_scheduler;

    localparam int NPE = 5;
    localparam int RPP = 5;
    localparam int NTS = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  req;
    logic [4:0]  req_ack;
    logic        mem_rd_en;
    logic [8:0]  mem_rd_addr;
    logic [24:0] mem_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] out_packet;
    logic        busy;
    logic        ts_done;
    logic [3:0]  ts_count;
    logic        err;

    int errors = 0;
    int checks = 0;
    int pe_rows [NPE];
    int timer   [NPE];
    int gseq    [64];
    int rdlog   [64];
    int ts_model, bcast_exp, n_input, n_bcast, rd_count, ng, ts_done_cnt;
    bit auto_pe;

    imem_row_scheduler #(
        .NUM_PE(NPE), .ROWS_PER_PE(RPP), .NUM_TIMESTEPS(NTS),
        .DATA_W(25), .ADDR_W(9), .IMEM_ID(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .req(req), .req_ack(req_ack),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_packet(out_packet),
        .busy(busy), .ts_done(ts_done), .ts_count(ts_count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [24:0] rowval(input int a);
        return 25'((a * 32'h0001_3579) ^ 32'h00AB_CDEF);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        req = '0;
        for (int p = 0; p < NPE; p++) begin pe_rows[p] = 0; timer[p] = 0; end
        ts_model = 0; bcast_exp = 0; n_input = 0; n_bcast = 0;
        rd_count = 0; ng = 0; ts_done_cnt = 0;
    endtask

    task automatic handle_xfer(input logic [32:0] pkt);
        int d;
        int op;
        d  = int'(pkt[32:29]);
        op = int'(pkt[28:25]);
        if (op == 1) begin
            check("in_dest_range", 64'(d < NPE), 1);
            if (d < NPE) begin
                check("row_limit", 64'(pe_rows[d] < RPP), 1);
                check("row_data", 64'(pkt[24:0]), 64'(rowval(ts_model*NPE*RPP + d*RPP + pe_rows[d])));
                pe_rows[d]++;
                if (auto_pe && pe_rows[d] < RPP) timer[d] = 2;
            end
            if (ng < 64) gseq[ng] = d;
            ng++;
            n_input++;
        end else begin
            check("bcast_op", 64'(op), 15);
            check("bcast_dest", 64'(d), 64'(bcast_exp));
            check("bcast_data", 64'(pkt[24:0]), 0);
            bcast_exp++;
            n_bcast++;
            if (bcast_exp == NPE) begin
                bcast_exp = 0;
                ts_model++;
                for (int p = 0; p < NPE; p++) pe_rows[p] = 0;
            end
        end
    endtask

    // One clock: observe the handshake as it stood at the edge, then react just after it.
    task automatic tick();
        logic        pv, pr, prd;
        logic [32:0] pp;
        logic [8:0]  pa;
        pv = out_valid; pr = out_ready; pp = out_packet; prd = mem_rd_en; pa = mem_rd_addr;
        @(posedge clk);
        #1;
        mem_rd_data = prd ? rowval(int'(pa)) : 25'h1555555;
        if (prd) begin
            if (rd_count < 64) rdlog[rd_count] = int'(pa);
            rd_count++;
        end
        if (ts_done) ts_done_cnt++;
        if (auto_pe) begin
            for (int p = 0; p < NPE; p++) if (req[p] && req_ack[p]) req[p] = 1'b0;
            for (int p = 0; p < NPE; p++) begin
                if (timer[p] > 0) begin
                    timer[p]--;
                    if (timer[p] == 0) req[p] = 1'b1;
                end
            end
        end
        if (pv && pr) handle_xfer(pp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        reset_model();
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        bit got;
        int r2, rdc, c1, c3, mx;
        logic [32:0] held;

        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; mem_rd_data = '0; auto_pe = 1'b0;
        reset_model();
        tick(); tick();
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_packet", 64'(out_packet), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_err", 64'(err), 0);
        check("rst_ts_count", 64'(ts_count), 0);
        check("rst_ts_done", 64'(ts_done), 0);
        check("rst_req_ack", 64'(req_ack), 0);
        check("rst_mem_rd_en", 64'(mem_rd_en), 0);
        rst_n = 1'b1;
        tick();

        // Full run, two timesteps, PEs re-request two cycles after each row
        auto_pe = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        check("busy_after_start", 64'(busy), 1);
        got = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            if (i == 10) start = 1'b1;
            tick();
            start = 1'b0;
            if (ts_done) got = 1;
        end
        check("ts1_done_seen", 64'(got), 1);
        for (int k = 0; k < 5; k++) begin
            check("first_grant", 64'(gseq[k]), 64'(k));
            check("first_addr", 64'(rdlog[k]), 64'(5*k));
        end
        check("ts1_inputs", 64'(n_input), 25);
        check("ts1_bcasts", 64'(n_bcast), 5);
        check("ts1_count", 64'(ts_count), 1);
        check("ts1_busy", 64'(busy), 1);
        check("ts1_err", 64'(err), 0);

        got = 0;
        for (int i = 0; i < 600 && !got; i++) begin
            tick();
            if (ts_done) got = 1;
        end
        check("ts2_done_seen", 64'(got), 1);
        check("ts2_first_addr", 64'(rdlog[25]), 25);
        check("ts2_first_grant", 64'(gseq[25]), 0);
        mx = 0;
        for (int k = 25; k < 50; k++) if (rdlog[k] > mx) mx = rdlog[k];
        check("ts2_last_addr", 64'(mx), 49);
        check("total_reads", 64'(rd_count), 50);
        check("total_inputs", 64'(n_input), 50);
        check("ts_done_pulses", 64'(ts_done_cnt), 2);
        check("final_ts_count", 64'(ts_count), 2);
        check("final_busy", 64'(busy), 0);
        check("final_err", 64'(err), 0);

        // Round-robin fairness with PE 1 and PE 3 requesting continuously
        auto_pe = 1'b0;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (n_input == 5) got = 1;
        end
        check("rr_push_done", 64'(got), 1);
        req[1] = 1'b1; req[3] = 1'b1;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            if (n_input == 13) got = 1;
        end
        check("rr_rows_done", 64'(got), 1);
        c1 = 1; c3 = 1;
        for (int k = 0; k < 8; k++) begin
            check("rr_order", 64'(gseq[5+k]), (k % 2 == 0) ? 64'd1 : 64'd3);
            if (gseq[5+k] == 1) c1++;
            if (gseq[5+k] == 3) c3++;
            check("rr_balance", 64'((c1 - c3 <= 1) && (c3 - c1 <= 1)), 1);
        end
        for (int i = 0; i < 20; i++) tick();
        check("rr_no_sixth", 64'(n_input), 13);
        req = '0;

        // Backpressure on the first PE 2 row, then over-request from PE 0
        auto_pe = 1'b1;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (out_valid && out_packet[32:29] == 4'd2 && out_packet[28:25] == 4'd1) got = 1;
        end
        check("bp_pe2_valid", 64'(got), 1);
        out_ready = 1'b0;
        held = out_packet;
        rdc  = rd_count;
        r2   = pe_rows[2];
        for (int i = 0; i < 7; i++) begin
            tick();
            check("bp_valid_hold", 64'(out_valid), 1);
            check("bp_packet_hold", 64'(out_packet), 64'(held));
        end
        check("bp_no_extra_rd", 64'(rd_count), 64'(rdc));
        check("bp_rows_held", 64'(pe_rows[2]), 64'(r2));
        out_ready = 1'b1;
        tick();
        check("bp_rows_inc", 64'(pe_rows[2]), 64'(r2 + 1));

        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            if (pe_rows[0] == RPP) got = 1;
        end
        check("ovr_pe0_full", 64'(got), 1);
        check("ovr_err_before", 64'(err), 0);
        req[0] = 1'b1;
        got = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            tick();
            if (req_ack[0]) got = 1;
        end
        check("ovr_req_ack", 64'(got), 1);
        check("ovr_err", 64'(err), 1);
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            if (ts_done) got = 1;
        end
        check("ovr_ts_done", 64'(got), 1);
        check("ovr_inputs", 64'(n_input), 25);
        check("ovr_ts_count", 64'(ts_count), 1);

        // Asynchronous reset while a packet is being offered
        out_ready = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (out_valid) got = 1;
        end
        check("rst_mid_valid", 64'(got), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 0);
        check("rst_mid_busy", 64'(busy), 0);
        check("rst_mid_err", 64'(err), 0);
        reset_model();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (n_input >= 1) got = 1;
        end
        check("restart_first_pkt", 64'(got), 1);
        check("restart_addr", 64'(rdlog[0]), 0);
        check("restart_grant", 64'(gseq[0]), 0);
        check("restart_ts_count", 64'(ts_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_row_scheduler.md
Name: imem_row_scheduler

Overview:
- Clocked controller that owns the input-row memory (I_MEM, node ID 10) and sequences input-row delivery to the NUM_PE partial-sum PEs.
- Pushes each PE its first row at timestep start, then serves PE row requests under round-robin arbitration.
- Reads the 25-bit spike row and emits an OP_INPUT packet to the granted PE.
- After every PE has received ROWS_PER_PE rows, broadcasts OP_TIMESTEP_DONE and advances the timestep counter.

Parameters:
- NUM_PE, 5, number of partial-sum PEs served (PE IDs 0..NUM_PE-1).
- ROWS_PER_PE, 5, input rows delivered to each PE per timestep.
- NUM_TIMESTEPS, 10, timesteps per run.
- DATA_W, 25, input row width (1 bit per spike).
- ADDR_W, 9, memory row address width.
- IMEM_ID, 10, node ID of this block on the packet network.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run; ignored unless IDLE.
- req  in  NUM_PE  level request from PE p for its next row.
- req_ack  out  NUM_PE  one-cycle pulse; request from PE p latched.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_W  memory row address.
- mem_rd_data  in  DATA_W  read data, valid the cycle after mem_rd_en.
- out_valid  out  1  packet valid.
- out_ready  in  1  downstream accepts packet.
- out_packet  out  33  [32:29] dest PE, [28:25] opcode, [24:0] data.
- busy  out  1  high whenever not IDLE.
- ts_done  out  1  one-cycle pulse when a timestep's broadcast completes.
- ts_count  out  4  completed timesteps in current run.
- err  out  1  sticky; request from a PE that already has ROWS_PER_PE rows.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: all outputs 0.
  - Internal state: FSM=IDLE; pend, row_cnt[], rr_ptr cleared.
  - rst_n low mid-operation aborts immediately; any packet in flight is dropped and out_valid falls asynchronously.
- FSM states: IDLE, ARB, READ, SEND, BCAST.
- IDLE:
  - start=1 -> ARB, with ts_count=0, pend=all ones, row_cnt[]=0, rr_ptr=0, err unchanged.
- Request capture (any non-IDLE state):
  - Each cycle, for every p with req[p]=1 and pend[p]=0, set pend[p] and pulse req_ack[p].
  - If pend[p]=1, the request is not acked, is held off, and is acked once pend[p] clears.
  - If row_cnt[p]==ROWS_PER_PE, the request is acked, dropped, and err=1.
  - If a grant clears pend[p] in the same cycle req[p]=1, req_ack[p] is not pulsed that cycle; it pulses the following cycle.
- ARB:
  - Pick the first p with pend[p]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_PE.
  - On grant: clear pend[p], latch gnt=p, rr_ptr=(p+1)%NUM_PE, assert mem_rd_en, go to READ.
  - mem_rd_addr = ts_count*NUM_PE*ROWS_PER_PE + p*ROWS_PER_PE + row_cnt[p], zero-extended/truncated to ADDR_W.
  - No pend and all row_cnt==ROWS_PER_PE: go to BCAST, with bcast_idx=0.
  - No pend otherwise: wait in ARB.
- READ:
  - One cycle; capture mem_rd_data.
  - Drive out_packet = {gnt[3:0], 4'd1, row}, out_valid=1; go to SEND.
- SEND:
  - Hold out_valid and out_packet stable until out_ready=1; that cycle is the transfer.
  - On transfer: row_cnt[gnt]++, out_valid falls next cycle, go to ARB.
  - Grant-to-valid latency = 2 cycles; minimum 3 cycles per row with out_ready tied high.
- BCAST:
  - Send {bcast_idx, 4'd15, 25'd0} for bcast_idx = 0..NUM_PE-1 in order, each with the same valid/ready rule.
  - After the last transfer: pulse ts_done and increment ts_count.
  - If ts_count reaches NUM_TIMESTEPS: go to IDLE.
  - Otherwise: pend=all ones, row_cnt[]=0, rr_ptr=0, go to ARB.
- Invariants:
  - out_valid never drops without a transfer, except on reset.
  - At most one packet is outstanding.
  - mem_rd_en is a single-cycle pulse per grant.
  - start while busy has no effect.

Test Plan:
- Single timestep, NUM_TIMESTEPS=1, out_ready=1, PEs re-request 2 cycles after each packet:
  - First five packets go to PE 0,1,2,3,4 with addrs 0,5,10,15,20.
  - 25 OP_INPUT packets total, then OP_TIMESTEP_DONE to PE 0..4.
  - ts_done pulses once, ts_count=1, busy falls.
- Round-robin fairness:
  - After the initial pushes, req[1] and req[3] are held high continuously from the same cycle.
  - Grants alternate 1,3,1,3; row_cnt[1] and row_cnt[3] never differ by more than 1.
- Backpressure:
  - out_ready=0 for 7 cycles during the PE 2 send.
  - out_valid and out_packet are unchanged for all 7 cycles; row_cnt[2] increments only on the ready cycle; no extra mem_rd_en.
- Over-request:
  - PE 0 asserts req after its 5th row.
  - req_ack[0] pulses, err=1, and no sixth packet is sent to PE 0.
- Multi-timestep addressing, NUM_TIMESTEPS=2:
  - Second timestep's first packet to PE 0 reads addr 25; PE 4's last row in timestep 2 reads addr 49.
  - ts_count=2 at the end.
- Reset mid-SEND:
  - rst_n low while out_valid=1: out_valid=0 immediately, busy=0.
  - After rst_n returns high, start restarts from addr 0.
